stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
// - Control/sequencing FSM for the MM:SS stopwatch. Sits between the button debouncer and the 7-seg display driver.
// - Consumes debounced button levels (reset, pause, select, adjust) and the divided-clock tick enables.
// - Owns the minute/second counters; sequences run/pause/adjust modes; emits per-field blanking for adjust-mode blink.
// PARAMETERS
// - FIELD_W  6   width of the minutes and seconds fields
// - MAX_SEC  59  last seconds value before wrap
// - MAX_MIN  59  last minutes value before wrap
// PORTS
// - clk        in   1        system clock; all logic on posedge
// - rst_n      in   1        async active-low reset
// - tick_1hz   in   1        1-cycle enable, run-mode count
// - tick_2hz   in   1        1-cycle enable, adjust-mode increment
// - tick_blink in   1        1-cycle enable, toggles blink phase
// - btn_rst    in   1        debounced level; rising edge clears time
// - btn_pause  in   1        debounced level; rising edge toggles pause
// - btn_sel    in   1        level; 1 = adjust minutes, 0 = adjust seconds
// - btn_adj    in   1        level; 1 = adjust mode while held
// - minutes    out  FIELD_W  current minutes, 0..MAX_MIN
// - seconds    out  FIELD_W  current seconds, 0..MAX_SEC
// - blank_min  out  1        1 = display blanks minutes digits
// - blank_sec  out  1        1 = display blanks seconds digits
// - mode       out  2        0 RUN, 1 PAUSED, 2 ADJUST
// BEHAVIOUR
// - Reset (rst_n=0, async): minutes=0, seconds=0, pause flag=0, mode=RUN, blink phase=0, blank_*=0.
//   Edge-detect registers (prev btn_rst, prev btn_pause) clear to 0.
// - Edges: rise = btn & ~prev, prev registered each cycle. A button held high through reset release fires one edge on the first clocked cycle.
// - mode is derived: btn_adj ? ADJUST : (pause ? PAUSED : RUN). Registered; updates one cycle after input change.
// - Pause edge toggles the pause flag in every mode. In ADJUST it takes effect on exit.
//   Releasing btn_adj returns to RUN or PAUSED per the flag.
// - RUN + tick_1hz: seconds+1. seconds==MAX_SEC -> 0 and carry minutes+1. minutes==MAX_MIN with carry -> 0.
//   59:59 -> 00:00. Outputs update on the cycle after the tick.
// - PAUSED: ticks ignored; time holds.
// - ADJUST + tick_2hz: selected field (per btn_sel, sampled in the tick cycle) +1, wrapping MAX->0.
//   No carry into the other field. tick_1hz ignored.
// - Priority per cycle: rst edge > adjust increment > run count. Rst edge with a tick in the same cycle -> 00:00; tick dropped.
//   Rst edge leaves the pause flag and mode unchanged.
// - Blink: phase toggles on tick_blink only in ADJUST. Phase forced to 0 in the cycle ADJUST is entered and whenever not in ADJUST.
//   blank_min = ADJUST & btn_sel & phase; blank_sec = ADJUST & ~btn_sel & phase.
//   Changing btn_sel mid-adjust moves blanking at once; phase is not reset.
// - Ticks are one-cycle enables; two ticks in the same cycle: only the one relevant to the current mode acts.
// - Counter arithmetic is FIELD_W unsigned. Values above MAX never occur.
// STRUCTURE
// - Shared package stopwatch_pkg: mode encoding localparams (MODE_RUN/PAUSED/ADJUST), FIELD_W, MAX_SEC, MAX_MIN defaults.
// - One sub-module, mod_counter: ports inc, clr, value, carry; params W and MAX.
//   Instantiated twice: seconds (carry -> minutes inc in RUN) and minutes.
//   Mode FSM, edge detect and blink stay in the top.
// TESTING
// - Reset then 61 tick_1hz in RUN -> minutes=1, seconds=1, mode=0, blank_*=0.
// - Preload 59:59 (via adjust), tick_1hz -> 00:00 next cycle.
// - btn_pause rise, 5 tick_1hz -> time unchanged, mode=1. Second rise then 1 tick -> seconds+1, mode=0.
// - btn_adj=1, btn_sel=0, seconds=59, tick_2hz -> seconds=0 with minutes unchanged.
//   btn_sel=1, 3 tick_2hz -> minutes+3. tick_blink -> blank_min=1, blank_sec=0.
// - btn_rst rise coincident with tick_1hz at 12:34 -> 00:00; mode unchanged.
// - Assert rst_n low mid-ADJUST with blank_min=1 -> all outputs 0 immediately (async). Held btn_adj gives mode=2 on the first clocked cycle after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the MM:SS stopwatch: field sizing defaults and the
// externally visible mode encoding.
package stopwatch_pkg;

    localparam int FIELD_W = 6;
    localparam int MAX_SEC = 59;
    localparam int MAX_MIN = 59;

    localparam logic [1:0] MODE_RUN    = 2'd0;
    localparam logic [1:0] MODE_PAUSED = 2'd1;
    localparam logic [1:0] MODE_ADJUST = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN    = MODE_RUN,
        ST_PAUSED = MODE_PAUSED,
        ST_ADJUST = MODE_ADJUST
    } mode_e;

endpackage

// File: rtl/stopwatch_ctrl_mod_counter.sv
// Modulo-(MAX+1) counter with synchronous clear and a carry that flags the
// wrap from MAX back to zero on an increment.
module mod_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= (r_value == MAX_V) ? '0 : r_value + W'(1);
        end
    end

    assign value = r_value;
    assign carry = inc & (r_value == MAX_V);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: button edge detection, RUN/PAUSED/ADJUST mode,
// adjust-mode blink phase, and the two cascaded time counters.
module stopwatch_ctrl #(
    parameter int FIELD_W = stopwatch_pkg::FIELD_W,
    parameter int MAX_SEC = stopwatch_pkg::MAX_SEC,
    parameter int MAX_MIN = stopwatch_pkg::MAX_MIN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_1hz,
    input  logic               tick_2hz,
    input  logic               tick_blink,
    input  logic               btn_rst,
    input  logic               btn_pause,
    input  logic               btn_sel,
    input  logic               btn_adj,
    output logic [FIELD_W-1:0] minutes,
    output logic [FIELD_W-1:0] seconds,
    output logic               blank_min,
    output logic               blank_sec,
    output logic [1:0]         mode
);

    import stopwatch_pkg::*;

    mode_e r_mode;
    mode_e w_mode_next;
    logic  r_prev_rst;
    logic  r_prev_pause;
    logic  r_pause;
    logic  r_phase;
    logic  w_pause_next;
    logic  w_phase_next;
    logic  w_rst_edge;
    logic  w_pause_edge;
    logic  w_in_run;
    logic  w_in_adj;
    logic  w_sec_inc;
    logic  w_min_inc;
    logic  w_sec_carry;
    logic  w_min_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode       <= ST_RUN;
            r_prev_rst   <= 1'b0;
            r_prev_pause <= 1'b0;
            r_pause      <= 1'b0;
            r_phase      <= 1'b0;
        end else begin
            r_mode       <= w_mode_next;
            r_prev_rst   <= btn_rst;
            r_prev_pause <= btn_pause;
            r_pause      <= w_pause_next;
            r_phase      <= w_phase_next;
        end
    end

    // Mode follows the post-toggle pause flag so a pause press shows up in
    // mode on the very next cycle; the blink phase only runs while in ADJUST.
    always_comb begin
        w_rst_edge   = btn_rst & ~r_prev_rst;
        w_pause_edge = btn_pause & ~r_prev_pause;
        w_pause_next = r_pause ^ w_pause_edge;
        w_phase_next = 1'b0;
        w_mode_next  = ST_RUN;
        if (btn_adj) begin
            w_mode_next = ST_ADJUST;
        end else if (w_pause_next) begin
            w_mode_next = ST_PAUSED;
        end
        case (r_mode)
            ST_ADJUST: w_phase_next = r_phase ^ tick_blink;
            default:   w_phase_next = 1'b0;
        endcase
    end

    assign w_in_run  = (r_mode == ST_RUN);
    assign w_in_adj  = (r_mode == ST_ADJUST);

    // Clear (button edge) outranks both increment sources inside the counters.
    assign w_sec_inc = (w_in_run & tick_1hz) | (w_in_adj & tick_2hz & ~btn_sel);
    assign w_min_inc = (w_in_run & w_sec_carry) | (w_in_adj & tick_2hz & btn_sel);

    mod_counter #(
        .W   (FIELD_W),
        .MAX (MAX_SEC)
    ) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_sec_inc),
        .clr   (w_rst_edge),
        .value (seconds),
        .carry (w_sec_carry)
    );

    mod_counter #(
        .W   (FIELD_W),
        .MAX (MAX_MIN)
    ) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_min_inc),
        .clr   (w_rst_edge),
        .value (minutes),
        .carry (w_min_carry)
    );

    assign mode      = r_mode;
    assign blank_min = w_in_adj & btn_sel & r_phase;
    assign blank_sec = w_in_adj & ~btn_sel & r_phase & ~w_min_carry;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a time-arithmetic reference model
// predicts each cycle's outputs, and a monitor compares after every edge.
module tb_stopwatch_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick1hz;
    logic       tick2hz;
    logic       tickBlink;
    logic       btnRst;
    logic       btnPause;
    logic       btnSel;
    logic       btnAdj;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       blankMin;
    logic       blankSec;
    logic [1:0] mode;

    typedef struct {
        int mm;
        int ss;
        int md;
        bit bm;
        bit bs;
    } exp_t;

    exp_t sbQ[$];

    int vecCount  = 0;
    int failCount = 0;

    int mMm;
    int mSs;
    int mMode;
    bit mPause;
    bit mPhase;
    bit mPrevRst;
    bit mPrevPause;

    stopwatch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick1hz),
        .tick_2hz   (tick2hz),
        .tick_blink (tickBlink),
        .btn_rst    (btnRst),
        .btn_pause  (btnPause),
        .btn_sel    (btnSel),
        .btn_adj    (btnAdj),
        .minutes    (minutes),
        .seconds    (seconds),
        .blank_min  (blankMin),
        .blank_sec  (blankSec),
        .mode       (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        mMm        = 0;
        mSs        = 0;
        mMode      = 0;
        mPause     = 0;
        mPhase     = 0;
        mPrevRst   = 0;
        mPrevPause = 0;
    endtask

    // Predict the state after the coming edge from the inputs now driven.
    task automatic modelStepPush();
        bit   rstRise;
        bit   pauseRise;
        int   total;
        exp_t e;
        rstRise   = btnRst && !mPrevRst;
        pauseRise = btnPause && !mPrevPause;
        if (pauseRise) mPause = !mPause;
        if (rstRise) begin
            mMm = 0;
            mSs = 0;
        end else if (mMode == 2 && tick2hz) begin
            if (btnSel) mMm = (mMm + 1) % 60;
            else        mSs = (mSs + 1) % 60;
        end else if (mMode == 0 && tick1hz) begin
            total = (mMm * 60 + mSs + 1) % 3600;
            mMm   = total / 60;
            mSs   = total % 60;
        end
        mPhase     = (mMode == 2) ? (mPhase ^ tickBlink) : 1'b0;
        mMode      = btnAdj ? 2 : (mPause ? 1 : 0);
        mPrevRst   = btnRst;
        mPrevPause = btnPause;
        e.mm = mMm;
        e.ss = mSs;
        e.md = mMode;
        e.bm = (mMode == 2) && btnSel && mPhase;
        e.bs = (mMode == 2) && !btnSel && mPhase;
        sbQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic r, input logic p, input logic s,
                                 input logic a, input logic t1, input logic t2,
                                 input logic tb);
        @(negedge clk);
        btnRst    = r;
        btnPause  = p;
        btnSel    = s;
        btnAdj    = a;
        tick1hz   = t1;
        tick2hz   = t2;
        tickBlink = tb;
        modelStepPush();
    endtask

    task automatic checkOutput(input string name, input int mm, input int ss,
                               input int md, input bit bm, input bit bs);
        vecCount++;
        if (minutes !== 6'(mm) || seconds !== 6'(ss) || mode !== 2'(md) ||
            blankMin !== bm || blankSec !== bs) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d:%0d mode=%0d bm=%b bs=%b, expected %0d:%0d mode=%0d bm=%b bs=%b",
                     name, minutes, seconds, mode, blankMin, blankSec, mm, ss, md, bm, bs);
        end
    endtask

    // Monitor: every clocked output is popped and compared against the model.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput("scoreboard", e.mm, e.ss, e.md, e.bm, e.bs);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        btnRst    = 1'b0;
        btnPause  = 1'b0;
        btnSel    = 1'b0;
        btnAdj    = 1'b0;
        tick1hz   = 1'b0;
        tick2hz   = 1'b0;
        tickBlink = 1'b0;
        modelReset();

        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset", 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        modelStepPush();

        for (int i = 0; i < 61; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0);
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
        end
        @(posedge clk); #2;
        checkOutput("run61", 1, 1, 0, 1'b0, 1'b0);

        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 64 && mSs != 59; i++) applyStimulus(0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 64 && mMm != 59; i++) applyStimulus(0, 0, 1, 1, 0, 1, 0);
        @(posedge clk); #2;
        checkOutput("preload", 59, 59, 2, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        @(posedge clk); #2;
        checkOutput("wrap", 0, 0, 0, 1'b0, 1'b0);

        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 1, 0, 0);
        @(posedge clk); #2;
        checkOutput("paused", 0, 0, 1, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        @(posedge clk); #2;
        checkOutput("resume", 0, 1, 0, 1'b0, 1'b0);

        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 64 && mSs != 59; i++) applyStimulus(0, 0, 0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1, 1, 0);
        @(posedge clk); #2;
        checkOutput("adjSecWrap", 0, 0, 2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, 1, 0);
        @(posedge clk); #2;
        checkOutput("adjMin", 3, 0, 2, 1'b0, 1'b0);
        applyStimulus(0, 0, 1, 1, 0, 0, 1);
        @(posedge clk); #2;
        checkOutput("blink", 3, 0, 2, 1'b1, 1'b0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        @(posedge clk); #2;
        checkOutput("blinkMove", 3, 0, 2, 1'b0, 1'b1);

        for (int i = 0; i < 64 && mMm != 12; i++) applyStimulus(0, 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 64 && mSs != 34; i++) applyStimulus(0, 0, 0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        checkOutput("preset", 12, 34, 0, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        @(posedge clk); #2;
        checkOutput("rstTick", 0, 0, 0, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 1);
        @(posedge clk); #2;
        checkOutput("preAsync", 0, 0, 2, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("asyncReset", 0, 0, 0, 1'b0, 1'b0);
        tickBlink = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        modelStepPush();
        @(posedge clk); #2;
        checkOutput("adjAfterReset", 0, 0, 2, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 29) == 0) ? ~btnRst : btnRst,
                          ($urandom_range(0, 19) == 0) ? ~btnPause : btnPause,
                          ($urandom_range(0, 9) == 0) ? ~btnSel : btnSel,
                          ($urandom_range(0, 39) == 0) ? ~btnAdj : btnAdj,
                          1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 2) == 0));
        end

        repeat (3) @(posedge clk);
        #2;
        if (sbQ.size() != 0) begin
            vecCount++;
            failCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sbQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
